// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared constants for the load/store unit.
// Size encodings, FSM state codes and default geometry.
package mem_lsu_pkg;

   localparam int S_DEF = 32;
   localparam int L_DEF = 256;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // state | meaning
   // IDLE  | serve loads / word stores; start a sub-word store by reading the old word
   // MERGE | write back the old word with the captured lane replaced
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_MERGE = 1'b1;

   // Encoding 11 behaves as a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] sz);
      return (sz == 2'b11) ? SZ_WORD : sz;
   endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// mem_lsu_lane: combinational lane logic for the load/store unit.
// Load side picks a little-endian lane and extends it; store side merges
// the low bits of the store data into an existing word.
module mem_lsu_lane
   import mem_lsu_pkg::*;
#(
   parameter int S = S_DEF
) (
   input  logic [S-1:0] ld_word_i,
   input  logic [1:0]   ld_off_i,
   input  logic [1:0]   ld_size_i,
   input  logic         ld_unsigned_i,
   output logic [S-1:0] ld_data_o,
   input  logic [S-1:0] st_old_i,
   input  logic [S-1:0] st_wdata_i,
   input  logic [1:0]   st_off_i,
   input  logic [1:0]   st_size_i,
   output logic [S-1:0] st_word_o
);

   function automatic logic [S-1:0] load_extract(input logic [S-1:0] word,
                                                 input logic [1:0]   off,
                                                 input logic [1:0]   size,
                                                 input logic         uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: return uns ? {{(S-8){1'b0}}, b}  : {{(S-8){b[7]}}, b};
         SZ_HALF: return uns ? {{(S-16){1'b0}}, h} : {{(S-16){h[15]}}, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [S-1:0] store_merge(input logic [S-1:0] old,
                                                input logic [S-1:0] wdata,
                                                input logic [1:0]   off,
                                                input logic [1:0]   size);
      logic [S-1:0] w;
      w = old;
      case (size)
         SZ_BYTE: w[{off, 3'b000} +: 8]     = wdata[7:0];
         SZ_HALF: w[{off[1], 4'b0000} +: 16] = wdata[15:0];
         default: w = wdata;
      endcase
      return w;
   endfunction

   // Pure lane steering, no state.
   always_comb begin
      ld_data_o = load_extract(ld_word_i, ld_off_i, ld_size_i, ld_unsigned_i);
      st_word_o = store_merge(st_old_i, st_wdata_i, st_off_i, st_size_i);
   end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the core and word-organised data memory.
// Loads are combinational; word stores take one cycle; byte/half stores
// are a read (stalled) followed by a merged write.
// Optional feature macro: MEM_LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// requests are suppressed and flagged; otherwise they are force-aligned.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int S = S_DEF,
   parameter int L = L_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          req_addr,
   input  logic [S-1:0]         req_wdata,
   input  logic                 req_read,
   input  logic                 req_write,
   input  logic [1:0]           req_size,
   input  logic                 req_unsigned,
   output logic                 stall,
   output logic [S-1:0]         rdata,
   output logic                 misalign,
   output logic [$clog2(L)-1:0] mem_a,
   output logic [S-1:0]         mem_din,
   input  logic [S-1:0]         mem_dout,
   output logic                 mem_read,
   output logic                 mem_write
);

   localparam int AW = $clog2(L);

   logic [0:0]    state_q, state_d;
   logic [S-1:0]  old_q, old_d;
   logic [S-1:0]  wdata_q, wdata_d;
   logic [1:0]    off_q, off_d;
   logic [1:0]    size_q, size_d;
   logic [AW-1:0] addr_q, addr_d;

   logic [1:0]    size_n;
   logic [1:0]    off_n;
   logic          trap;
   logic [S-1:0]  ld_data;
   logic [S-1:0]  merged;
   logic          unused_addr_hi;

   // Address bits above the memory range are ignored, so accesses wrap.
   assign unused_addr_hi = ^req_addr[31:AW+2];
   assign size_n         = norm_size(req_size);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
   logic misalign_q;
   logic mis;

   // Misaligned requests are blocked and leave a sticky flag behind.
   always_comb begin
      mis  = ((size_n == SZ_HALF) && req_addr[0]) ||
             ((size_n == SZ_WORD) && (req_addr[1:0] != 2'b00));
      trap = mis && (req_read || req_write);
      off_n = req_addr[1:0];
   end

   // Sticky misalign flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_q <= 1'b0;
      else if ((state_q == ST_IDLE) && trap) misalign_q <= 1'b1;
   end

   assign misalign = misalign_q;
`else
   // Without trapping, low address bits are forced to natural alignment.
   always_comb begin
      trap = 1'b0;
      case (size_n)
         SZ_BYTE: off_n = req_addr[1:0];
         SZ_HALF: off_n = {req_addr[1], 1'b0};
         default: off_n = 2'b00;
      endcase
   end

   assign misalign = 1'b0;
`endif

   mem_lsu_lane #(.S(S)) u_lane (
      .ld_word_i     (mem_dout),
      .ld_off_i      (off_n),
      .ld_size_i     (size_n),
      .ld_unsigned_i (req_unsigned),
      .ld_data_o     (ld_data),
      .st_old_i      (old_q),
      .st_wdata_i    (wdata_q),
      .st_off_i      (off_q),
      .st_size_i     (size_q),
      .st_word_o     (merged)
   );

   // Request decode, memory strobes and next-state / capture selection.
   always_comb begin
      state_d   = state_q;
      old_d     = old_q;
      wdata_d   = wdata_q;
      off_d     = off_q;
      size_d    = size_q;
      addr_d    = addr_q;
      stall     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_din   = '0;
      mem_a     = req_addr[AW+1:2];
      rdata     = '0;
      case (state_q)
         ST_IDLE: begin
            if (!trap) begin
               if (req_read) rdata = ld_data;
               if (req_write) begin
                  if (size_n == SZ_WORD) begin
                     mem_write = 1'b1;
                     mem_din   = req_wdata;
                  end else begin
                     mem_read = 1'b1;
                     stall    = 1'b1;
                     state_d  = ST_MERGE;
                     old_d    = mem_dout;
                     wdata_d  = req_wdata;
                     off_d    = off_n;
                     size_d   = size_n;
                     addr_d   = req_addr[AW+1:2];
                  end
               end else if (req_read) begin
                  mem_read = 1'b1;
               end
            end
         end
         ST_MERGE: begin
            mem_a     = addr_q;
            mem_write = 1'b1;
            mem_din   = merged;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and capture registers; reset drops any pending merge at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         old_q   <= '0;
         wdata_q <= '0;
         off_q   <= '0;
         size_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         old_q   <= old_d;
         wdata_q <= wdata_d;
         off_q   <= off_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu with a byte-array reference model.
// Honours MEM_LSU_MISALIGN_TRAP_EN when compiled with it.
module tb_mem_lsu;

   localparam int S = 32;
   localparam int L = 256;
   localparam int AW = 8;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   req_addr;
   logic [S-1:0]  req_wdata;
   logic          req_read, req_write, req_unsigned;
   logic [1:0]    req_size;
   logic          stall, misalign, mem_read, mem_write;
   logic [S-1:0]  rdata, mem_din, mem_dout;
   logic [AW-1:0] mem_a;

   mem_lsu #(.S(S), .L(L)) dut (
      .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_read(req_read), .req_write(req_write), .req_size(req_size),
      .req_unsigned(req_unsigned), .stall(stall), .rdata(rdata),
      .misalign(misalign), .mem_a(mem_a), .mem_din(mem_din),
      .mem_dout(mem_dout), .mem_read(mem_read), .mem_write(mem_write)
   );

   always #5 clk = ~clk;

   // Synchronous data memory with combinational read.
   logic [31:0] mem [0:L-1];
   logic [31:0] img [0:L-1];
   logic        do_init;
   assign mem_dout = mem[mem_a];
   always @(posedge clk) begin
      if (do_init) begin
         for (int i = 0; i < L; i++) mem[i] <= img[i];
      end else if (mem_write) begin
         mem[mem_a] <= mem_din;
      end
   end

   // Reference model: plain byte array, little-endian.
   logic [7:0] rbytes [0:4*L-1];

   typedef struct {logic [7:0] a; logic [31:0] d;} wr_t;
   wr_t         exp_wr[$];
   logic [31:0] exp_rd[$];
   int          nvec = 0;
   int          nerr = 0;
   logic        exp_mis = 1'b0;
   logic        mon_en = 1'b0;

   function automatic logic [1:0] nsz(input logic [1:0] sz);
      return (sz == 2'd3) ? 2'd2 : sz;
   endfunction

   function automatic int nbytes(input logic [1:0] sz);
      return 1 << nsz(sz);
   endfunction

   function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
      int n;
      n = nbytes(sz);
      return (a % n) != 0;
   endfunction

   function automatic logic [9:0] eff(input logic [31:0] a, input logic [1:0] sz);
      int n;
      int e;
      n = nbytes(sz);
      e = int'(a % 1024);
      if (!TRAP) e = e - (e % n);
      return 10'(e);
   endfunction

   function automatic logic [31:0] ref_word(input int wa);
      return {rbytes[4*wa+3], rbytes[4*wa+2], rbytes[4*wa+1], rbytes[4*wa]};
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                            input logic uns);
      int          ea, n;
      logic [31:0] v;
      ea = int'(eff(a, sz));
      n  = nbytes(sz);
      v  = 32'd0;
      for (int k = 0; k < n; k++) v = v | (32'(rbytes[ea+k]) << (8*k));
      if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      int ea, n;
      wr_t w;
      ea = int'(eff(a, sz));
      n  = nbytes(sz);
      for (int k = 0; k < n; k++) rbytes[ea+k] = 8'(d >> (8*k));
      w.a = 8'(ea / 4);
      w.d = ref_word(ea / 4);
      exp_wr.push_back(w);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_b(input string nm, input logic act, input logic exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   task automatic idle_req();
      req_read  = 1'b0;
      req_write = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes or a load is presented.
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         if (mem_write) begin
            if (exp_wr.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_write: mem_a=%h mem_din=%h, expected no write", mem_a, mem_din);
            end else begin
               wr_t w;
               w = exp_wr.pop_front();
               chk("wr_addr", 32'(mem_a), 32'(w.a));
               chk("wr_data", mem_din, w.d);
            end
         end
         if (req_read && !req_write) begin
            if (exp_rd.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_load: rdata=%h, expected none queued", rdata);
            end else begin
               chk("rdata", rdata, exp_rd.pop_front());
            end
         end
      end
   end

   // Tasks start just after a rising edge and end just after the next one.
   task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                          input bit use_c, input logic [31:0] c);
      bit tr;
      tr = TRAP && is_mis(a, sz);
      if (tr) exp_mis = 1'b1;
      exp_rd.push_back(use_c ? c : (tr ? 32'd0 : ref_load(a, sz, uns)));
      req_addr = a; req_size = sz; req_unsigned = uns; req_read = 1'b1; req_write = 1'b0;
      @(negedge clk);
      chk_b("ld_stall", stall, 1'b0);
      chk_b("ld_mem_read", mem_read, !tr);
      if (!tr) chk("ld_mem_a", 32'(mem_a), 32'(eff(a, sz) >> 2));
      @(posedge clk); #1;
      idle_req();
      chk_b("misalign", misalign, exp_mis);
   endtask

   task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      bit tr;
      tr = TRAP && is_mis(a, sz);
      if (tr) exp_mis = 1'b1;
      else ref_store(a, sz, d);
      req_addr = a; req_size = sz; req_wdata = d; req_read = 1'b0; req_write = 1'b1;
      req_unsigned = $urandom_range(0, 1);
      @(negedge clk);
      if (tr || nsz(sz) == 2'd2) begin
         chk_b("st_stall", stall, 1'b0);
         chk_b("st_write", mem_write, !tr);
         @(posedge clk); #1;
         idle_req();
      end else begin
         chk_b("rmw_stall1", stall, 1'b1);
         chk_b("rmw_write1", mem_write, 1'b0);
         chk_b("rmw_read1", mem_read, 1'b1);
         @(posedge clk); #1;
         idle_req();
         @(negedge clk);
         chk_b("rmw_stall2", stall, 1'b0);
         chk_b("rmw_write2", mem_write, 1'b1);
         @(posedge clk); #1;
      end
      chk_b("misalign", misalign, exp_mis);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      logic [1:0]  sz;
      rst_n = 1'b0;
      req_size = 2'd0; req_unsigned = 1'b0;
      idle_req();
      for (int i = 0; i < L; i++) img[i] = $urandom;
      img[1] = 32'h8899_AABB;
      for (int i = 0; i < L; i++)
         for (int k = 0; k < 4; k++) rbytes[4*i+k] = 8'(img[i] >> (8*k));
      do_init = 1'b1;
      @(posedge clk); #1;
      do_init = 1'b0;
      @(negedge clk);
      chk_b("rst_stall", stall, 1'b0);
      chk_b("rst_mem_write", mem_write, 1'b0);
      chk_b("rst_mem_read", mem_read, 1'b0);
      chk_b("rst_misalign", misalign, 1'b0);
      chk("rst_rdata", rdata, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;

      do_load(32'h5, 2'd0, 1'b0, 1, 32'hFFFF_FFAA);
      do_load(32'h6, 2'd1, 1'b1, 1, 32'h0000_8899);
      do_load(32'h6, 2'd1, 1'b0, 1, 32'hFFFF_8899);

      // sh at 0x4 interrupted by reset while in MERGE.
      req_addr = 32'h4; req_size = 2'd1; req_wdata = 32'h7777; req_write = 1'b1;
      @(negedge clk);
      chk_b("rmwrst_stall1", stall, 1'b1);
      @(posedge clk); #1;
      idle_req();
      chk_b("rmwrst_merge_write", mem_write, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_b("rmwrst_write_drop", mem_write, 1'b0);
      chk_b("rmwrst_stall", stall, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_load(32'h4, 2'd2, 1'b0, 1, 32'h8899_AABB);

      do_store(32'h4, 2'd0, 32'h12);
      do_load(32'h4, 2'd2, 1'b0, 1, 32'h8899_AA12);
      do_store(32'h8, 2'd2, 32'hDEAD_BEEF);
      do_load(32'h8, 2'd2, 1'b0, 1, 32'hDEAD_BEEF);
      do_store(32'h3, 2'd1, 32'h0000_CAFE);
      do_load(32'h0, 2'd2, 1'b0, 0, 32'd0);
      do_load(32'h4, 2'd2, 1'b0, 0, 32'd0);

      for (int n = 0; n < 300; n++) begin
         a  = $urandom;
         a  = {a[31:10], 4'b0000, a[5:0]};
         d  = $urandom;
         sz = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) do_load(a, sz, 1'($urandom_range(0, 1)), 0, 32'd0);
         else do_store(a, sz, d);
      end

      // Reset clears the sticky flag.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_mis = 1'b0;
      @(posedge clk); #1;
      chk_b("post_rst_misalign", misalign, 1'b0);
      do_load(32'h8, 2'd2, 1'b0, 0, 32'd0);

      @(posedge clk); #1;
      if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
         nvec++;
         nerr++;
         $display("FAIL drain: %0d writes and %0d loads left, expected 0", exp_wr.size(), exp_rd.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
